// File: rtl/mult_share_sched.sv
// mult_share_sched: one signed fixed-point multiplier shared round-robin by
// N_REQ requesters. An accepted operand pair travels a fixed PIPE_STAGES-deep
// pipeline and returns, tagged with its requester index, in acceptance order.
// Optional build macro MULT_SAT_EN: clamp the rescaled product to the C_BITS
// range and add a registered sat_flag output; otherwise the product wraps.
module mult_share_sched #(
    parameter int N_REQ       = 4,
    parameter int A_BITS      = 18,
    parameter int A_POINT     = 14,
    parameter int B_BITS      = 18,
    parameter int B_POINT     = 14,
    parameter int C_BITS      = 18,
    parameter int C_POINT     = 14,
    parameter int PIPE_STAGES = 2,
    localparam int ID_BITS    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int INF_BITS   = $clog2(PIPE_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*A_BITS-1:0]   req_a,
    input  logic [N_REQ*B_BITS-1:0]   req_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      res_valid,
    output logic [ID_BITS-1:0]        res_id,
    output logic signed [C_BITS-1:0]  res_c,
    output logic [INF_BITS-1:0]       inflight
`ifdef MULT_SAT_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam int P_BITS = A_BITS + B_BITS;
    localparam int RSHIFT = A_POINT + B_POINT - C_POINT;
    localparam int RS_POS = (RSHIFT > 0) ? RSHIFT : 0;
    localparam int LSHIFT = (RSHIFT < 0) ? -RSHIFT : 0;
    // widened so a left rescale keeps every bit for overflow detection
    localparam int S_BITS = P_BITS + LSHIFT;
    localparam int LAST   = PIPE_STAGES - 1;

    // Align the full-precision product to the result's binary point.
    function automatic logic signed [S_BITS-1:0] rescale(input logic signed [P_BITS-1:0] p);
        logic signed [S_BITS-1:0] w;
        w = S_BITS'(p);
        return (w >>> RS_POS) <<< LSHIFT;
    endfunction

`ifdef MULT_SAT_EN
    // True when the value does not fit in C_BITS signed.
    function automatic logic is_ovf(input logic signed [S_BITS-1:0] v);
        logic [S_BITS-C_BITS:0] top;
        top = v[S_BITS-1:C_BITS-1];
        return !((&top) || !(|top));
    endfunction

    // Clamp to the representable C_BITS range.
    function automatic logic signed [C_BITS-1:0] sat_c(input logic signed [S_BITS-1:0] v);
        if (is_ovf(v)) begin
            return v[S_BITS-1] ? {1'b1, {(C_BITS-1){1'b0}}} : {1'b0, {(C_BITS-1){1'b1}}};
        end
        return v[C_BITS-1:0];
    endfunction
`endif

    logic [ID_BITS-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]       gnt_idx;
    logic                     xfer;
    logic signed [A_BITS-1:0] a_sel;
    logic signed [B_BITS-1:0] b_sel;
    logic [INF_BITS-1:0]      inflight_q, inflight_d;

    logic                     vld_q [PIPE_STAGES];
    logic [ID_BITS-1:0]       id_q  [PIPE_STAGES];
    logic signed [A_BITS-1:0] a_q   [PIPE_STAGES];
    logic signed [B_BITS-1:0] b_q   [PIPE_STAGES];

    logic signed [P_BITS-1:0] prod;
    logic signed [S_BITS-1:0] scaled;
    logic signed [C_BITS-1:0] c_d;

    logic                     res_valid_q;
    logic [ID_BITS-1:0]       res_id_q;
    logic signed [C_BITS-1:0] res_c_q;

    // Round-robin grant: first valid at or above rr_ptr, else first valid from 0.
    always_comb begin
        logic                hi_found, lo_found;
        logic [ID_BITS-1:0]  hi_idx, lo_idx;
        hi_found  = 1'b0;
        lo_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = ID_BITS'(j);
                if (j >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_BITS'(j);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        xfer    = lo_found & ~rst;
        for (int j = 0; j < N_REQ; j++) begin
            if (xfer && (gnt_idx == ID_BITS'(j))) begin
                req_ready[j] = 1'b1;
                a_sel        = req_a[j*A_BITS +: A_BITS];
                b_sel        = req_b[j*B_BITS +: B_BITS];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == ID_BITS'(N_REQ - 1)) ? '0 : gnt_idx + ID_BITS'(1);
        end
        inflight_d = inflight_q + INF_BITS'(xfer) - INF_BITS'(vld_q[LAST]);
    end

    // Multiply and rescale the operands leaving the last pipeline stage.
    always_comb begin
        prod   = P_BITS'(a_q[LAST]) * P_BITS'(b_q[LAST]);
        scaled = rescale(prod);
`ifdef MULT_SAT_EN
        c_d    = sat_c(scaled);
`else
        c_d    = scaled[C_BITS-1:0];
`endif
    end

`ifndef MULT_SAT_EN
    logic unused_hi;
    assign unused_hi = ^scaled[S_BITS-1:C_BITS];
`endif

    // Control state: pointer, stage valids and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) vld_q[s] <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            vld_q[0]   <= xfer;
            for (int s = 1; s < PIPE_STAGES; s++) vld_q[s] <= vld_q[s-1];
        end
    end

    // Operand/id pipeline; stage 0 captures the granted pair.
    always_ff @(posedge clk) begin
        a_q[0]  <= a_sel;
        b_q[0]  <= b_sel;
        id_q[0] <= gnt_idx;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            a_q[s]  <= a_q[s-1];
            b_q[s]  <= b_q[s-1];
            id_q[s] <= id_q[s-1];
        end
    end

    // Result register; id/value hold between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_c_q     <= '0;
        end else begin
            res_valid_q <= vld_q[LAST];
            if (vld_q[LAST]) begin
                res_id_q <= id_q[LAST];
                res_c_q  <= c_d;
            end
        end
    end

`ifdef MULT_SAT_EN
    logic sat_q;
    // Clamp indicator, only high alongside a result that was clamped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= vld_q[LAST] & is_ovf(scaled);
    end
    assign sat_flag = sat_q;
`endif

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_c     = res_c_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched: the stimulus side predicts grants and
// results from a round-robin/arithmetic model; a monitor checks every result.
module tb_mult_share_sched;
    localparam int N  = 4;
    localparam int AB = 18;
    localparam int BB = 18;
    localparam int CB = 18;
    localparam int PS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]           req_valid;
    logic [N*AB-1:0]        req_a;
    logic [N*BB-1:0]        req_b;
    logic [N-1:0]           req_ready;
    logic                   res_valid;
    logic [1:0]             res_id;
    logic signed [CB-1:0]   res_c;
    logic [1:0]             inflight;
`ifdef MULT_SAT_EN
    logic                   sat_flag;
`endif

    mult_share_sched #(
        .N_REQ(N), .A_BITS(AB), .A_POINT(14), .B_BITS(BB), .B_POINT(14),
        .C_BITS(CB), .C_POINT(14), .PIPE_STAGES(PS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_id(res_id),
        .res_c(res_c),
        .inflight(inflight)
`ifdef MULT_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    typedef struct {
        int     id;
        longint c;
        bit     sat;
        int     due;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         accepted = 0;
    int         returned = 0;
    int         cyc      = 0;
    logic [1:0] m_ptr    = 2'd0;
    logic [N-1:0] last_ready;
    longint     a_in[N];
    longint     b_in[N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact product, floor-divide by 2^14, then wrap or clamp to 18 bits.
    function automatic longint model_c(input longint a, input longint b, output bit sat);
        longint v, lo, hi;
        v   = (a * b) >>> 14;
        hi  = (longint'(1) <<< 17) - 1;
        lo  = -(longint'(1) <<< 17);
        sat = 1'b0;
`ifdef MULT_SAT_EN
        if (v > hi) begin
            v = hi; sat = 1'b1;
        end else if (v < lo) begin
            v = lo; sat = 1'b1;
        end
`else
        v = v & ((longint'(1) <<< 18) - 1);
        if (v > hi) v = v - (longint'(1) <<< 18);
`endif
        return v;
    endfunction

    function automatic longint rnd18();
        logic signed [17:0] t;
        t = 18'($urandom);
        return longint'(t);
    endfunction

    // One clock of stimulus: drive at negedge, check grant, predict result.
    task automatic cycle(input logic [N-1:0] v);
        logic [1:0]   g;
        logic [1:0]   idx;
        bit           found;
        exp_t         e;
        logic [N-1:0] exp_r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_a[i*AB +: AB] = AB'(a_in[i]);
            req_b[i*BB +: BB] = BB'(b_in[i]);
        end
        req_valid = v;
        #1;
        found = 1'b0;
        g     = 2'd0;
        for (int i = 0; i < N; i++) begin
            idx = m_ptr + 2'(i);
            if (!found && v[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_r = found ? (4'b0001 << g) : 4'b0000;
        last_ready = req_ready;
        chk("grant", longint'(req_ready), longint'(exp_r));
        if (found) begin
            e.id  = int'(g);
            e.c   = model_c(a_in[g], b_in[g], e.sat);
            e.due = cyc + 1 + PS;
            sb_q.push_back(e);
            accepted++;
            m_ptr = g + 2'd1;
        end
    endtask

    // Monitor: compare every presented result with the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (res_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d c=%0d, expected no result", res_id, res_c);
                end else begin
                    e = sb_q.pop_front();
                    returned++;
                    chk("res_latency", cyc, e.due);
                    chk("res_id", longint'(res_id), e.id);
                    chk("res_c", longint'(res_c), e.c);
`ifdef MULT_SAT_EN
                    chk("sat_flag", longint'(sat_flag), longint'(e.sat));
`endif
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    returned++;
                    checks++;
                    errors++;
                    $display("FAIL missing_result: got none at cycle %0d, expected id=%0d c=%0d", cyc, e.id, e.c);
                end
`ifdef MULT_SAT_EN
                chk("sat_idle", longint'(sat_flag), 0);
`endif
            end
            chk("inflight", longint'(inflight), accepted - returned);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        longint ta[5];
        longint tbv[5];
        int     waited;
        bit     got3;
        ta  = '{-16384, -1, 1, 65536, -65536};
        tbv = '{ 16384,  1, 1, 65536,  65536};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i] = 0;
            b_in[i] = 0;
        end

        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_id", longint'(res_id), 0);
        chk("rst_res_c", longint'(res_c), 0);
        chk("rst_inflight", longint'(inflight), 0);
        req_valid = 4'hF;
        #1;
        chk("rst_ready", longint'(req_ready), 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // all requesters valid: rotating grants, back-to-back results
        repeat (8) begin
            for (int i = 0; i < N; i++) begin
                a_in[i] = rnd18();
                b_in[i] = rnd18();
            end
            cycle(4'hF);
        end
        repeat (3) cycle(4'h0);

        // requester 2 alone: 0.5 * 0.5
        a_in[2] = 8192;
        b_in[2] = 8192;
        cycle(4'b0100);
        repeat (4) cycle(4'h0);

        // rescale boundaries on requester 1
        for (int k = 0; k < 5; k++) begin
            a_in[1] = ta[k];
            b_in[1] = tbv[k];
            cycle(4'b0010);
        end
        repeat (3) cycle(4'h0);

        // reset while two operations are in flight
        for (int i = 0; i < N; i++) begin
            a_in[i] = rnd18();
            b_in[i] = rnd18();
        end
        cycle(4'b0011);
        cycle(4'b1000);
        cycle(4'h0);
        rst = 1'b1;
        sb_q.delete();
        accepted = 0;
        returned = 0;
        m_ptr    = 2'd0;
        #1;
        chk("midrst_inflight", longint'(inflight), 0);
        chk("midrst_res_valid", longint'(res_valid), 0);
        chk("midrst_res_id", longint'(res_id), 0);
        chk("midrst_res_c", longint'(res_c), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'hF);
        chk("first_after_rst", longint'(last_ready), 1);
        repeat (4) cycle(4'h0);

        // fairness: requester 0 always valid, requester 3 raised until served
        cycle(4'b0001);
        cycle(4'b0001);
        waited = 0;
        got3   = 1'b0;
        for (int w = 0; w < N + 2; w++) begin
            cycle(4'b1001);
            if (last_ready[3]) begin
                got3 = 1'b1;
                break;
            end
            waited++;
        end
        chk("fair_req3_served", longint'(got3), 1);
        chk("fair_req3_wait_ok", longint'(waited <= N - 1), 1);
        cycle(4'b0001);
        chk("fair_req0_resumes", longint'(last_ready), 1);
        repeat (3) cycle(4'h0);

        // random traffic
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                a_in[i] = rnd18();
                b_in[i] = rnd18();
            end
            cycle(4'($urandom));
        end

        repeat (PS + 3) cycle(4'h0);
        chk("drain_empty", longint'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Time-multiplexes one signed fixed-point multiplier across N_REQ requesters, e.g. several filter taps or channel-model terms sharing a single DSP slice.
- A round-robin scheduler accepts at most one operand pair per cycle.
- Each accepted pair enters a fixed-latency multiply/rescale pipeline.
- The result comes back tagged with the requester index.

Parameters:
- N_REQ, 4, number of requesters (>=1)
- A_BITS, 18, operand a width (signed)
- A_POINT, 14, fractional bits of a
- B_BITS, 18, operand b width (signed)
- B_POINT, 14, fractional bits of b
- C_BITS, 18, result width (signed)
- C_POINT, 14, fractional bits of result
- PIPE_STAGES, 2, accept-to-result latency in cycles (>=1)
- localparam ID_BITS = max(1, clog2(N_REQ))

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand pair valid
- req_a  in  N_REQ*A_BITS  packed operand a; requester i at [i*A_BITS +: A_BITS]
- req_b  in  N_REQ*B_BITS  packed operand b, same packing
- req_ready  out  N_REQ  one-hot (or zero) grant; a transfer occurs when req_valid[i] & req_ready[i]
- res_valid  out  1  result valid, one-cycle pulse per accepted request
- res_id  out  ID_BITS  requester index of the result
- res_c  out  C_BITS  signed fixed-point product
- inflight  out  clog2(PIPE_STAGES+1)  number of accepted, not-yet-returned operations

Behaviour:
- Reset: every output and register is 0 immediately on rst, independent of clk: rr_ptr=0, pipeline valid bits=0, res_valid=0, res_id=0, res_c=0, inflight=0.
- Reset mid-operation discards all in-flight operations; no result is emitted for them after rst deasserts.
- Grant: combinational from req_valid and rr_ptr.
  - Search starts at index rr_ptr, ascending, wrapping from N_REQ-1 to 0.
  - The first asserted req_valid is granted; req_ready has at most one bit set.
  - req_ready is 0 while rst is high.
- Pointer: on a transfer from requester g, rr_ptr <= (g+1) mod N_REQ. No transfer means rr_ptr holds. With N_REQ=1, rr_ptr stays 0.
- Fairness: a continuously valid requester waits at most N_REQ-1 cycles.
- No backpressure on results; the consumer must always sink res_valid.
- The pipeline never stalls, so a transfer is possible every cycle.
- Pipeline stage 0 (transfer cycle +1) registers the a/b operands, id and valid.
- The full-precision product prod is A_BITS+B_BITS wide, signed.
- Rescale: with rshift = A_POINT+B_POINT-C_POINT, rshift>=0 gives prod >>> rshift (arithmetic, floor toward -inf); rshift<0 gives prod <<< -rshift.
- The result is truncated to the low C_BITS (two's-complement wrap) unless MULT_SAT_EN is defined.
- Latency: a transfer at rising edge k gives res_valid=1 with the matching res_id/res_c during the cycle after edge k+PIPE_STAGES.
- Results return in acceptance order.
- res_id/res_c hold their last values when res_valid=0.
- inflight: +1 on a transfer and -1 on res_valid, both applied in the same cycle (net 0). Maximum value is PIPE_STAGES.
- If a requester's req_valid drops without a grant, nothing is recorded and no state changes.

Optional Feature:
- Macro MULT_SAT_EN.
- Defined:
  - The rescaled value is clamped to [-2^(C_BITS-1), 2^(C_BITS-1)-1] before output.
  - Output port sat_flag (1 bit) is added. It is registered, asserts alongside res_valid when clamping occurred, and is 0 otherwise and on reset.
- Undefined: wrap-around truncation as above; no sat_flag port.

Test Plan:
- Defaults. Requester 2 alone sends a=8192 (0.5), b=8192 → response 2 cycles later: res_valid=1, res_id=2, res_c=4096, inflight 1→0.
- All 4 requesters valid for 8 cycles → grants 0,1,2,3,0,1,2,3; the res_id sequence matches with 2-cycle lag; inflight holds 2.
- Truncation:
  - a=-16384, b=16384 → res_c=-16384.
  - a=-1, b=1 → res_c=-1 (floor).
  - a=1, b=1 → res_c=0.
- Overflow: a=65536 (4.0), b=65536.
  - Without MULT_SAT_EN → res_c=0 (wrap).
  - With it → res_c=131071 and sat_flag=1.
  - With it, a=-65536, b=65536 → res_c=-131072 and sat_flag=1.
- Reset mid-operation: two transfers in flight, then rst pulsed asynchronously between edges → outputs 0 immediately, no res_valid afterwards, rr_ptr=0, so the next grant with all valid goes to requester 0.
- Fairness: requester 0 is valid continuously and requester 3 is raised on one cycle → requester 3 is granted within 3 cycles, and requester 0 resumes on the next cycle.
